// File: rtl/entrada_notas.sv
// ---------------------------------------------------------------------------
// entrada_notas
//
// Input stage for the note-sequence word classifier. Cleans up the raw note
// switches and the bouncy confirm button, queues each confirmed note in a
// small FIFO and replays it as a paced presentation: nota is set up, ok is
// pulsed, then nota is held for a gap before the next note may appear.
//
// Optional feature (macro FIM_BLOQUEIO_EN): adds input `fim`. While fim=1
// the queue is flushed, presses are discarded silently and the sequencer is
// forced back to idle (aborting a note in flight).
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   botao     in   raw confirm button (async, bouncy)
//   chaves    in   raw note switches [3:0] (async)
//   fim       in   classifier end-of-word block (FIM_BLOQUEIO_EN only)
//   nota      out  note presented to the classifier [3:0]
//   ok        out  note-confirm strobe (registered)
//   contagem  out  FIFO occupancy [$clog2(DEPTH):0]
//   cheio     out  FIFO full
//   perdido   out  sticky: a press was dropped on a full FIFO
//
// Sequencer states:
//   state   | meaning
//   OCIOSO  | idle, ok=0; loads nota from FIFO head when queue not empty
//   PREPARA | nota stable, ok=0 for SETUP cycles (setup margin)
//   PULSO   | ok=1 for OK_WIDTH cycles
//   ESPERA  | ok=0, nota held for GAP cycles; head popped on exit
// ---------------------------------------------------------------------------
module entrada_notas #(
  parameter int DEB_CYCLES = 16,
  parameter int OK_WIDTH   = 2,
  parameter int SETUP      = 1,
  parameter int GAP        = 2,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     botao,
  input  logic [3:0]               chaves,
`ifdef FIM_BLOQUEIO_EN
  input  logic                     fim,
`endif
  output logic [3:0]               nota,
  output logic                     ok,
  output logic [$clog2(DEPTH):0]   contagem,
  output logic                     cheio,
  output logic                     perdido
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int TMAX = (SETUP > OK_WIDTH) ? ((SETUP > GAP) ? SETUP : GAP)
                                           : ((OK_WIDTH > GAP) ? OK_WIDTH : GAP);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    PREPARA = 2'd1,
    PULSO   = 2'd2,
    ESPERA  = 2'd3
  } estado_t;

  // ---------------------------------------------------------------------
  // Block input
  // ---------------------------------------------------------------------
  logic fim_act;
`ifdef FIM_BLOQUEIO_EN
  assign fim_act = fim;
`else
  assign fim_act = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Two-flop synchronizers
  // ---------------------------------------------------------------------
  logic       botao_m_q, botao_s_q;
  logic [3:0] chaves_m_q, chaves_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      botao_m_q  <= 1'b0;
      botao_s_q  <= 1'b0;
      chaves_m_q <= 4'b0000;
      chaves_s_q <= 4'b0000;
    end else begin
      botao_m_q  <= botao;
      botao_s_q  <= botao_m_q;
      chaves_m_q <= chaves;
      chaves_s_q <= chaves_m_q;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: btn_deb follows botao_s only after DEB_CYCLES stable cycles
  // ---------------------------------------------------------------------
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          btn_deb_q, btn_deb_d;
  logic          push_req;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    btn_deb_d = btn_deb_q;
    push_req  = 1'b0;
    if (botao_s_q == btn_deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
      btn_deb_d = ~btn_deb_q;
      deb_cnt_d = '0;
      // only the press edge queues a note; release is ignored
      push_req  = ~btn_deb_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_q <= '0;
      btn_deb_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      btn_deb_q <= btn_deb_d;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          cheio_q, perdido_q, perdido_d;
  logic          pop, push_ok, full;

  estado_t       state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (state_q == ESPERA) && (tmr_q == '0);
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    perdido_d = perdido_q;
    if (fim_act) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop)     rd_d = rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_req && !push_ok) perdido_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      cheio_q   <= 1'b0;
      perdido_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      cheio_q   <= (count_d == CW'(DEPTH));
      perdido_q <= perdido_d;
    end
  end

  // storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (!reset && !fim_act && push_ok) begin
      mem[wr_q] <= chaves_s_q;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer (timer is a down-counter, loaded with N-1 on state entry)
  // ---------------------------------------------------------------------
  logic [3:0] nota_q, nota_d;
  logic       ok_q, ok_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    nota_d  = nota_q;
    case (state_q)
      OCIOSO: begin
        if (count_q != '0) begin
          nota_d  = mem[rd_q];
          state_d = PREPARA;
          tmr_d   = TW'(SETUP - 1);
        end
      end
      PREPARA: begin
        if (tmr_q == '0) begin
          state_d = PULSO;
          tmr_d   = TW'(OK_WIDTH - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      PULSO: begin
        if (tmr_q == '0) begin
          state_d = ESPERA;
          tmr_d   = TW'(GAP - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ESPERA: begin
        if (tmr_q == '0) begin
          state_d = OCIOSO;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = OCIOSO;
        tmr_d   = '0;
      end
    endcase
    if (fim_act) begin
      state_d = OCIOSO;
      tmr_d   = '0;
    end
    // ok registered from next state so it tracks PULSO exactly, glitch-free
    ok_d = (state_d == PULSO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OCIOSO;
      tmr_q   <= '0;
      nota_q  <= 4'b0000;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      nota_q  <= nota_d;
      ok_q    <= ok_d;
    end
  end

  assign nota     = nota_q;
  assign ok       = ok_q;
  assign contagem = count_q;
  assign cheio    = cheio_q;
  assign perdido  = perdido_q;

endmodule
